// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: request kinds, access sizes,
// FSM states and big-endian lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_RSVD  = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] OFS_B0 = 2'd0;
    localparam logic [1:0] OFS_B3 = 2'd3;
    localparam logic [1:0] OFS_H0 = 2'd0;
    localparam logic [1:0] OFS_H1 = 2'd2;

    // Big-endian: byte offset 0 sits in the top lane, so the right shift is (3 - ofs) * 8.
    function automatic logic [4:0] lane_shift(input logic [1:0] ofs);
        return {~ofs, 3'b000};
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational byte/halfword lane logic: extract-and-extend for loads and
// insert-into-old-word for read-modify-write stores (big-endian lanes).
module mem_lane_merge
    import mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rd_word,
    input  logic [DW-1:0] old_word,
    input  logic [DW-1:0] wdata,
    input  logic [1:0]    ofs,
    input  logic [1:0]    size,
    input  logic          sext,
    output logic [DW-1:0] load_val,
    output logic [DW-1:0] store_word
);

    function automatic logic [DW-1:0] extract_ext(input logic [DW-1:0] w,
                                                  input logic [1:0]    o,
                                                  input logic [1:0]    sz,
                                                  input logic          s);
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        b = 8'(w >> lane_shift(o));
        h = 16'(w >> lane_shift({o[1], 1'b1}));
        case (sz)
            SIZE_BYTE: r = {{(DW-8){s & b[7]}}, b};
            SIZE_HALF: r = {{(DW-16){s & h[15]}}, h};
            default:   r = w;
        endcase
        return r;
    endfunction

    // Store data arrives right-justified; the mask trims anything above the lane.
    function automatic logic [DW-1:0] insert_lane(input logic [DW-1:0] w,
                                                  input logic [DW-1:0] d,
                                                  input logic [1:0]    o,
                                                  input logic [1:0]    sz);
        logic [DW-1:0] mask;
        logic [4:0]    sh;
        case (sz)
            SIZE_BYTE: begin
                sh   = lane_shift(o);
                mask = DW'(8'hFF) << sh;
            end
            SIZE_HALF: begin
                sh   = lane_shift({o[1], 1'b1});
                mask = DW'(16'hFFFF) << sh;
            end
            default: begin
                sh   = 5'd0;
                mask = '1;
            end
        endcase
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    assign load_val   = extract_ext(rd_word, ofs, size, sext);
    assign store_word = insert_lane(old_word, wdata, ofs, size);

endmodule

// File: rtl/mem_access_unit.sv
// Initiator-side memory sequencer holding IR and MDR for the multi-cycle core.
// Define MEM_SUBWORD_EN to build byte/half accesses and the RMW store path.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_kind,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [DW-1:0] ir,
    output logic [DW-1:0] mdr,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    state_t        state, state_nxt;
    logic [1:0]    kind_q;
    logic          err_q;
    logic [AW-3:0] waddr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] mdr_q;
    logic          req_err;
    logic          accept;
    logic [DW-1:0] load_val;
    logic [DW-1:0] store_word;

    assign accept = (state == ST_IDLE) && req_valid;

`ifdef MEM_SUBWORD_EN
    logic [1:0]    ofs_q;
    logic [1:0]    size_q;
    logic [1:0]    size_eff;
    logic          signed_q;
    logic [DW-1:0] merge_q;

    // Instruction fetches are always whole words regardless of req_size.
    always_comb begin
        size_eff = (req_kind == KIND_FETCH) ? SIZE_WORD : req_size;
        case (size_eff)
            SIZE_BYTE: req_err = 1'b0;
            SIZE_HALF: req_err = req_addr[0];
            SIZE_WORD: req_err = |req_addr[1:0];
            default:   req_err = 1'b1;
        endcase
        if (req_kind == KIND_RSVD) req_err = 1'b1;
    end

    mem_lane_merge #(.DW(DW)) u_lane (
        .rd_word    (mem_rd),
        .old_word   (merge_q),
        .wdata      (wdata_q),
        .ofs        (ofs_q),
        .size       (size_q),
        .sext       (signed_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) merge_q <= '0;
        else if (state == ST_RMW_RD) merge_q <= mem_rd;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ofs_q    <= req_addr[1:0];
            size_q   <= size_eff;
            signed_q <= req_signed;
        end
    end
`else
    logic unused_subword;
    assign unused_subword = ^{req_size, req_signed};
    assign req_err    = (req_kind == KIND_RSVD) || (req_addr[1:0] != 2'b00);
    assign load_val   = mem_rd;
    assign store_word = wdata_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        mem_a      = '0;
        mem_wd     = '0;
        mem_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                     state_nxt = ST_RESP;
                    else if (req_kind != KIND_STORE) state_nxt = ST_READ;
`ifdef MEM_SUBWORD_EN
                    else if (size_eff != SIZE_WORD)  state_nxt = ST_RMW_RD;
`endif
                    else                             state_nxt = ST_WRITE;
                end
            end
            ST_READ: begin
                mem_a     = {waddr_q, 2'b00};
                state_nxt = ST_RESP;
            end
`ifdef MEM_SUBWORD_EN
            ST_RMW_RD: begin
                mem_a     = {waddr_q, 2'b00};
                state_nxt = ST_WRITE;
            end
`endif
            ST_WRITE: begin
                mem_a     = {waddr_q, 2'b00};
                mem_wd    = store_word;
                // Gated by reset so a write caught by reset never reaches memory.
                mem_we    = reset_n;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kind_q <= '0;
            err_q  <= 1'b0;
            ir_q   <= '0;
            mdr_q  <= '0;
        end else begin
            if (accept) begin
                kind_q <= req_kind;
                err_q  <= req_err;
            end
            if (state == ST_READ) begin
                if (kind_q == KIND_FETCH) ir_q  <= mem_rd;
                else                      mdr_q <= load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            waddr_q <= req_addr[AW-1:2];
            wdata_q <= req_wdata;
        end
    end

    assign ir  = ir_q;
    assign mdr = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a bench-owned word memory and a
// reference model of IR, MDR and memory contents. Honours MEM_SUBWORD_EN.
module tb_mem_access_unit;

    localparam logic [1:0] K_FETCH = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2, K_RSVD = 2'd3;
    localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
`ifdef MEM_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_signed = 1'b0;
    logic        resp_valid, resp_err;
    logic [31:0] ir, mdr, mem_a, mem_wd, mem_rd;
    logic        mem_we;

    always #5 clk = ~clk;

    mem_access_unit #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed), .resp_valid(resp_valid), .resp_err(resp_err),
        .ir(ir), .mdr(mdr), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd)
    );

    logic [31:0] mem [0:255];
    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

    typedef struct {
        logic        err;
        logic [31:0] ir;
        logic [31:0] mdr;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          resp_cyc[$];
    logic [31:0] ref_mem [0:255];
    logic [31:0] ir_m = '0, mdr_m = '0;
    int          n_checks = 0, n_errors = 0;
    int          cyc = 0, we_cnt = 0, stores_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] kind, input logic [31:0] addr,
                                       input logic [1:0] sz);
        if (kind == K_RSVD) return 1'b1;
        if (!SUBWORD || kind == K_FETCH) return addr[1:0] != 2'b00;
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return addr[0];
            SZ_W:    return addr[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] ofs,
                                               input logic [1:0] sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (ofs)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = ofs[1] ? w[15:0] : w[31:16];
        if (SUBWORD && sz == SZ_B) return (sgn && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
        if (SUBWORD && sz == SZ_H) return (sgn && h[15]) ? {16'hFFFF, h} : {16'h0, h};
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d,
                                                input logic [1:0] ofs, input logic [1:0] sz);
        logic [31:0] r;
        r = w;
        if (SUBWORD && sz == SZ_B) begin
            case (ofs)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else if (SUBWORD && sz == SZ_H) begin
            if (ofs[1]) r[15:0]  = d[15:0];
            else        r[31:16] = d[15:0];
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Response monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            chk("ready_in_resp", req_ready, 1'b0);
            if (sb.size() == 0) begin
                chk("resp_unexpected", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_err", resp_err, e.err);
                chk("resp_ir", ir, e.ir);
                chk("resp_mdr", mdr, e.mdr);
                chk("resp_cycle", cyc, e.due);
            end
            resp_cyc.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic issue(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sgn, input logic hold);
        exp_t x;
        int   lat, guard, idx;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            chk("ready_timeout", req_ready, 1'b1);
            return;
        end
        req_valid  = 1'b1;
        req_kind   = kind;
        req_addr   = addr;
        req_wdata  = wd;
        req_size   = sz;
        req_signed = sgn;
        idx   = int'(addr[9:2]);
        x.err = model_err(kind, addr, sz);
        if (x.err)                                        lat = 1;
        else if (kind == K_STORE && SUBWORD && sz != SZ_W) lat = 3;
        else                                               lat = 2;
        if (!x.err) begin
            case (kind)
                K_FETCH: ir_m  = ref_mem[idx];
                K_LOAD:  mdr_m = model_load(ref_mem[idx], addr[1:0], sz, sgn);
                default: begin
                    ref_mem[idx] = model_store(ref_mem[idx], wd, addr[1:0], sz);
                    stores_exp++;
                end
            endcase
        end
        x.ir  = ir_m;
        x.mdr = mdr_m;
        x.due = cyc + lat;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        chk("ready_busy", req_ready, 1'b0);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        int          we0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        mem[2]  = 32'h2067FFF7; ref_mem[2]  = 32'h2067FFF7;
        mem[20] = 32'h11223344; ref_mem[20] = 32'h11223344;
        mem[24] = 32'h55555555; ref_mem[24] = 32'h55555555;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", req_ready, 1'b1);
            chk("rst_resp_valid", resp_valid, 1'b0);
            chk("rst_resp_err", resp_err, 1'b0);
            chk("rst_ir", ir, 32'h0);
            chk("rst_mdr", mdr, 32'h0);
            chk("rst_mem_a", mem_a, 32'h0);
            chk("rst_mem_wd", mem_wd, 32'h0);
            chk("rst_mem_we", mem_we, 1'b0);
        end
        reset_n = 1'b1;

        // Fetch.
        issue(K_FETCH, 32'h8, 32'h0, SZ_W, 1'b0, 1'b0);
        chk("fetch_mem_a", mem_a, 32'h8);
        drain();
        chk("fetch_ir", ir, 32'h2067FFF7);

        // Word store then word load.
        issue(K_STORE, 32'h44, 32'hDEADBEEF, SZ_W, 1'b0, 1'b0);
        chk("st_we_c1", mem_we, 1'b1);
        chk("st_wd_c1", mem_wd, 32'hDEADBEEF);
        chk("st_a_c1", mem_a, 32'h44);
        @(posedge clk); #1;
        chk("st_we_c2", mem_we, 1'b0);
        chk("st_wd_c2", mem_wd, 32'h0);
        drain();
        chk("st_mem", mem[17], 32'hDEADBEEF);
        issue(K_LOAD, 32'h44, 32'h0, SZ_W, 1'b1, 1'b0);
        drain();
        chk("ld_mdr", mdr, 32'hDEADBEEF);

        // Misaligned and reserved requests.
        issue(K_LOAD, 32'h46, 32'h0, SZ_W, 1'b0, 1'b0);
        chk("mis_resp_valid", resp_valid, 1'b1);
        chk("mis_resp_err", resp_err, 1'b1);
        chk("mis_mem_a", mem_a, 32'h0);
        drain();
        chk("mis_mdr", mdr, 32'hDEADBEEF);
        issue(K_RSVD, 32'h40, 32'h0, SZ_W, 1'b0, 1'b0);
        drain();
        issue(K_STORE, 32'h42, 32'hCAFEF00D, SZ_W, 1'b0, 1'b0);
        chk("mis_st_we", mem_we, 1'b0);
        drain();
        chk("mis_st_mem", mem[16], 32'h1000_0010);

`ifdef MEM_SUBWORD_EN
        issue(K_STORE, 32'h51, 32'h000000AA, SZ_B, 1'b0, 1'b0);
        chk("sb_we_c1", mem_we, 1'b0);
        chk("sb_a_c1", mem_a, 32'h50);
        @(posedge clk); #1;
        chk("sb_we_c2", mem_we, 1'b1);
        chk("sb_wd_c2", mem_wd, 32'h11AA3344);
        drain();
        chk("sb_mem", mem[20], 32'h11AA3344);
        issue(K_LOAD, 32'h51, 32'h0, SZ_B, 1'b1, 1'b0);
        drain();
        chk("lb_signed", mdr, 32'hFFFFFFAA);
        issue(K_LOAD, 32'h52, 32'h0, SZ_H, 1'b0, 1'b0);
        drain();
        chk("lh_unsigned", mdr, 32'h00003344);
        issue(K_STORE, 32'h50, 32'h1234BEEF, SZ_H, 1'b0, 1'b0);
        drain();
        chk("sh_mem", mem[20], 32'hBEEF3344);
        issue(K_LOAD, 32'h50, 32'h0, SZ_H, 1'b1, 1'b0);
        drain();
        chk("lh_signed", mdr, 32'hFFFFBEEF);
        issue(K_LOAD, 32'h53, 32'h0, SZ_B, 1'b0, 1'b0);
        drain();
        chk("lb_unsigned", mdr, 32'h00000044);
        issue(K_LOAD, 32'h53, 32'h0, SZ_H, 1'b0, 1'b0);
        drain();
        chk("lh_mis_mdr", mdr, 32'h00000044);
`else
        issue(K_LOAD, 32'h51, 32'h0, SZ_B, 1'b1, 1'b0);
        chk("nosub_err", resp_err, 1'b1);
        drain();
        chk("nosub_mdr", mdr, 32'hDEADBEEF);
`endif

        // Handshake: valid held high across four word loads.
        resp_cyc.delete();
        issue(K_LOAD, 32'h44, 32'h0, SZ_W, 1'b0, 1'b1);
        issue(K_LOAD, 32'h08, 32'h0, SZ_W, 1'b0, 1'b1);
        issue(K_LOAD, 32'h60, 32'h0, SZ_W, 1'b0, 1'b1);
        issue(K_LOAD, 32'h0C, 32'h0, SZ_W, 1'b0, 1'b0);
        drain();
        chk("hs_count", resp_cyc.size(), 4);
        if (resp_cyc.size() == 4)
            for (int i = 1; i < 4; i++) chk("hs_gap", resp_cyc[i] - resp_cyc[i-1], 3);

        // Reset asserted while in WRITE drops the store.
        saved = ref_mem[24];
        we0   = we_cnt;
        issue(K_STORE, 32'h60, 32'h12345678, SZ_W, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("rstw_we_gated", mem_we, 1'b0);
        repeat (2) @(negedge clk);
        sb.delete();
        ref_mem[24] = saved;
        stores_exp--;
        ir_m  = '0;
        mdr_m = '0;
        chk("rstw_mem", mem[24], 32'h55555555);
        chk("rstw_we_cnt", we_cnt, we0);
        chk("rstw_ir", ir, 32'h0);
        chk("rstw_mdr", mdr, 32'h0);
        chk("rstw_ready", req_ready, 1'b1);
        reset_n = 1'b1;

        // Random mix, all checked through the scoreboard.
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            a = {22'h0, 8'($urandom_range(32, 63)), 2'($urandom_range(0, 3))};
            issue(2'($urandom_range(0, 3)), a, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'b0);
        end
        drain();
        for (int i = 32; i < 64; i++) chk("rand_mem", mem[i], ref_mem[i]);
        chk("we_total", we_cnt, stores_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
